frame_compare_checker: RTL and testbench

- Parametrised on-chip frame checker for the Gaussian/DoG pipeline: streams a DUT result buffer and a golden buffer beat by beat and compares them with a programmable tolerance.
- Accumulates mismatch statistics and emits a back-pressured mismatch log.
- Sits beside the blur and keypoint memories so frame checking can run in BIST mode, without simulator backdoor access.
- Generalises frame size, pixel width, lanes per beat and tolerance.

---
 rtl/frame_compare_checker.sv | 217 +++++++++++++++++++++
 tb/tb_frame_compare_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_compare_checker.sv
// Frame checker: streams a DUT buffer and a golden buffer in raster order, compares
// each pixel against a tolerance, keeps mismatch statistics and a back-pressured log.
//
// state | meaning
// IDLE  | waiting for start; stats and log payload hold their last values
// RUN   | issuing one beat per unstalled cycle
// DRAIN | last beat issued, waiting for its compare to retire
// DONE  | one-cycle done pulse
module frame_compare_checker #(
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int PIX_W  = 8,
    parameter int LANES  = 1,
    parameter int ROW_W  = 10,
    parameter int BEAT_W = 10,
    parameter int CNT_W  = 20,
    localparam int COL_W = BEAT_W + $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [PIX_W-1:0]        tol,
    output logic                    rd_en,
    output logic [ROW_W-1:0]        rd_row,
    output logic [BEAT_W-1:0]       rd_beat,
    input  logic [LANES*PIX_W-1:0]  dut_data,
    input  logic [LANES*PIX_W-1:0]  gold_data,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        err_count,
    output logic [ROW_W-1:0]        first_row,
    output logic [COL_W-1:0]        first_col,
    output logic [PIX_W-1:0]        max_abs,
    output logic                    log_valid,
    input  logic                    log_ready,
    output logic [ROW_W-1:0]        log_row,
    output logic [BEAT_W-1:0]       log_beat,
    output logic [LANES-1:0]        log_mask
);

    localparam int BPR     = COLS / LANES;
    localparam int N_BEATS = ROWS * BPR;
    localparam int LEFT_W  = $clog2(N_BEATS + 1);
    localparam int LIDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int POP_W   = $clog2(LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic               stall;
    logic               start_ok;
    logic               kill;
    logic               last_beat;
    logic               cmp_fire;
    logic [LEFT_W-1:0]  beats_left;
    logic [PIX_W-1:0]   tol_q;
    logic               cmp_valid;
    logic [ROW_W-1:0]   cmp_row;
    logic [BEAT_W-1:0]  cmp_beat;
    logic               first_seen;

    logic [PIX_W-1:0]   lane_abs [LANES];
    logic [LANES-1:0]   mask;
    logic [PIX_W-1:0]   beat_max;
    logic [POP_W-1:0]   pop;
    logic [LIDX_W-1:0]  low_lane;
    logic [CNT_W:0]     err_sum;

    // A pending record that the consumer refuses freezes both issue and compare.
    assign stall     = log_valid && !log_ready;
    assign start_ok  = (state == S_IDLE) && start && !abort;
    assign kill      = abort && ((state == S_RUN) || (state == S_DRAIN));
    assign last_beat = (beats_left == LEFT_W'(1));
    assign cmp_fire  = cmp_valid && !stall;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)                   state_nxt = S_IDLE;
                else if (rd_en && last_beat) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)       state_nxt = S_IDLE;
                else if (!stall) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_RUN: begin
                rd_en = !stall;
                busy  = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Raster address generator; beats_left counts down to the terminal beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_row     <= '0;
            rd_beat    <= '0;
            beats_left <= '0;
            tol_q      <= '0;
        end else if (start_ok) begin
            rd_row     <= '0;
            rd_beat    <= '0;
            beats_left <= LEFT_W'(N_BEATS);
            tol_q      <= tol;
        end else if (kill) begin
            rd_row     <= '0;
            rd_beat    <= '0;
            beats_left <= '0;
        end else if (rd_en) begin
            beats_left <= beats_left - LEFT_W'(1);
            if (rd_beat == BEAT_W'(BPR - 1)) begin
                rd_beat <= '0;
                rd_row  <= (rd_row == ROW_W'(ROWS - 1)) ? '0 : rd_row + ROW_W'(1);
            end else begin
                rd_beat <= rd_beat + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid <= 1'b0;
            cmp_row   <= '0;
            cmp_beat  <= '0;
        end else if (kill) begin
            cmp_valid <= 1'b0;
        end else if (!stall) begin
            cmp_valid <= rd_en;
            if (rd_en) begin
                cmp_row  <= rd_row;
                cmp_beat <= rd_beat;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PIX_W-1:0] d_pix;
        logic [PIX_W-1:0] g_pix;
        assign d_pix       = dut_data[l*PIX_W +: PIX_W];
        assign g_pix       = gold_data[l*PIX_W +: PIX_W];
        assign lane_abs[l] = (d_pix >= g_pix) ? d_pix - g_pix : g_pix - d_pix;
        assign mask[l]     = lane_abs[l] > tol_q;
    end

    // Walk lanes high to low so the lowest mismatching lane wins low_lane.
    always_comb begin
        beat_max = '0;
        pop      = '0;
        low_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_abs[l] > beat_max) beat_max = lane_abs[l];
            pop = pop + POP_W'(mask[l]);
            if (mask[l]) low_lane = LIDX_W'(l);
        end
    end

    assign err_sum = {1'b0, err_count} + (CNT_W + 1)'(pop);

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_count  <= '0;
            first_row  <= '0;
            first_col  <= '0;
            max_abs    <= '0;
            first_seen <= 1'b0;
        end else if (cmp_fire) begin
            err_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            if (beat_max > max_abs) max_abs <= beat_max;
            if ((|mask) && !first_seen) begin
                first_seen <= 1'b1;
                first_row  <= cmp_row;
                first_col  <= COL_W'(cmp_beat) * COL_W'(LANES) + COL_W'(low_lane);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_valid <= 1'b0;
            log_row   <= '0;
            log_beat  <= '0;
            log_mask  <= '0;
        end else if (kill) begin
            log_valid <= 1'b0;
        end else if (!stall) begin
            log_valid <= cmp_valid && (|mask);
            if (cmp_valid && (|mask)) begin
                log_row  <= cmp_row;
                log_beat <= cmp_beat;
                log_mask <= mask;
            end
        end
    end

endmodule

// File: tb/tb_frame_compare_checker.sv
// Directed bench for frame_compare_checker on an 8x4 frame with 2 lanes per beat;
// a whole-frame reference model produces the expected log, stats and timing.
module tb_frame_compare_checker;

    localparam int COLS   = 8;
    localparam int ROWS   = 4;
    localparam int PIX_W  = 8;
    localparam int LANES  = 2;
    localparam int ROW_W  = 10;
    localparam int BEAT_W = 10;
    localparam int CNT_W  = 4;
    localparam int BPR    = COLS / LANES;
    localparam int N      = ROWS * BPR;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, start, abort, log_ready;
    logic [PIX_W-1:0] tol;
    logic rd_en;
    logic [ROW_W-1:0] rd_row;
    logic [BEAT_W-1:0] rd_beat;
    logic [LANES*PIX_W-1:0] dut_data = '0;
    logic [LANES*PIX_W-1:0] gold_data = '0;
    logic busy, done;
    logic [CNT_W-1:0] err_count;
    logic [ROW_W-1:0] first_row;
    logic [BEAT_W:0] first_col;
    logic [PIX_W-1:0] max_abs;
    logic log_valid;
    logic [ROW_W-1:0] log_row;
    logic [BEAT_W-1:0] log_beat;
    logic [LANES-1:0] log_mask;

    frame_compare_checker #(
        .COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .LANES(LANES),
        .ROW_W(ROW_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tol(tol),
        .rd_en(rd_en), .rd_row(rd_row), .rd_beat(rd_beat),
        .dut_data(dut_data), .gold_data(gold_data),
        .busy(busy), .done(done), .err_count(err_count),
        .first_row(first_row), .first_col(first_col), .max_abs(max_abs),
        .log_valid(log_valid), .log_ready(log_ready),
        .log_row(log_row), .log_beat(log_beat), .log_mask(log_mask)
    );

    always #5 clk = ~clk;

    logic [7:0] dmem [ROWS][COLS];
    logic [7:0] gmem [ROWS][COLS];

    // Buffers present data one cycle after rd_en and hold it otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int l = 0; l < LANES; l++) begin
                dut_data[l*PIX_W +: PIX_W]  <= dmem[int'(rd_row)][int'(rd_beat)*LANES + l];
                gold_data[l*PIX_W +: PIX_W] <= gmem[int'(rd_row)][int'(rd_beat)*LANES + l];
            end
        end
    end

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int n_pass = 0;
    int n_chk  = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    typedef struct {int row; int beat; int mask;} rec_t;
    rec_t exp_q[$];
    rec_t rec;
    int exp_err, exp_frow, exp_fcol, exp_max, exp_nrec;

    task automatic build_model(input int t);
        int raw, m, c, a;
        bit found;
        exp_q.delete();
        raw = 0; found = 0; exp_frow = 0; exp_fcol = 0; exp_max = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < BPR; b++) begin
                m = 0;
                for (int l = 0; l < LANES; l++) begin
                    c = b * LANES + l;
                    a = int'(dmem[r][c]) - int'(gmem[r][c]);
                    if (a < 0) a = -a;
                    if (a > exp_max) exp_max = a;
                    if (a > t) begin
                        m = m | (1 << l);
                        raw++;
                        if (!found) begin
                            found = 1; exp_frow = r; exp_fcol = c;
                        end
                    end
                end
                if (m != 0) exp_q.push_back('{r, b, m});
            end
        end
        exp_err  = (raw > SAT) ? SAT : raw;
        exp_nrec = exp_q.size();
    endtask

    task automatic set_frame(input int kind);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                gmem[r][c] = 8'(20 + r * 8 + c);
                dmem[r][c] = gmem[r][c];
                if (kind == 3) dmem[r][c] = gmem[r][c] + 8'd1;
                if (kind == 4) dmem[r][c] = gmem[r][c] ^ 8'($urandom);
            end
        if (kind == 1) dmem[2][5] = gmem[2][5] + 8'd3;
        if (kind == 2) begin
            dmem[1][0] = gmem[1][0] - 8'd4;
            dmem[1][1] = gmem[1][1] - 8'd4;
            dmem[3][7] = gmem[3][7] + 8'd1;
        end
    endtask

    bit mon_en = 0;
    bit held;
    logic [ROW_W+BEAT_W+LANES-1:0] held_pl;
    int start_edge, cyc, issue_idx, rd_cnt, rd_first, rd_last, rec_cnt, done_cyc;
    int first_mask, last_row, last_beat, last_mask;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc = edges - start_edge;
            if (log_valid && !log_ready) chk("stall_rd_en", rd_en, 0);
            if (rd_en) begin
                chk("rd_row", rd_row, issue_idx / BPR);
                chk("rd_beat", rd_beat, issue_idx % BPR);
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
                issue_idx++;
            end
            if (log_valid && held) chk("log_hold", {log_row, log_beat, log_mask}, held_pl);
            if (log_valid && log_ready) begin
                if (exp_q.size() == 0) chk("log_unexpected", log_valid, 0);
                else begin
                    rec = exp_q.pop_front();
                    chk("log_row", log_row, rec.row);
                    chk("log_beat", log_beat, rec.beat);
                    chk("log_mask", log_mask, rec.mask);
                    if (rec_cnt == 0) first_mask = log_mask;
                    last_row = log_row; last_beat = log_beat; last_mask = log_mask;
                    rec_cnt++;
                end
            end
            held    = log_valid && !log_ready;
            held_pl = {log_row, log_beat, log_mask};
            if (done) begin
                done_cyc = cyc;
                chk("done_busy", busy, 0);
                chk("err_count", err_count, exp_err);
                chk("first_row", first_row, exp_frow);
                chk("first_col", first_col, exp_fcol);
                chk("max_abs", max_abs, exp_max);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {rd_en, busy, done, log_valid}, 0);
        chk({tag, "_addr"}, {rd_row, rd_beat}, 0);
        chk({tag, "_stats"}, {err_count, first_row, first_col, max_abs}, 0);
        chk({tag, "_log"}, {log_row, log_beat, log_mask}, 0);
    endtask

    task automatic run_frame(input int t, input int stall_at, input int stall_len,
                             input int abort_at, input int rst_at, input int restart_at,
                             input int tol_at, input int tol_new);
        build_model(t);
        issue_idx = 0; rd_cnt = 0; rd_first = -1; rd_last = -1;
        rec_cnt = 0; done_cyc = -1; held = 0;
        first_mask = -1; last_row = -1; last_beat = -1; last_mask = -1;
        @(posedge clk); #1;
        tol = 8'(t); start = 1; log_ready = 1;
        start_edge = edges;
        mon_en = 1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == abort_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_log_valid", log_valid, 0);
            end
            if (c == rst_at + 1) chk_all_zero("rst_mid");
            start = (c == restart_at);
            abort = (c == abort_at);
            rst   = (c == rst_at);
            if (c == tol_at) tol = 8'(tol_new);
            log_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            if ((abort_at >= 0 || rst_at >= 0) && c >= 40) break;
            if (c == 60) chk("run_timeout", done_cyc >= 0, 1);
        end
        start = 0; abort = 0; rst = 0; log_ready = 1;
        repeat (2) @(posedge clk);
        #1 mon_en = 0;
        if (abort_at < 0 && rst_at < 0) begin
            chk("done_cycle", done_cyc, N + 2 + stall_len);
            chk("rd_first", rd_first, 1);
            chk("rd_last", rd_last, N + stall_len);
            chk("rd_count", rd_cnt, N);
            chk("rec_count", rec_cnt, exp_nrec);
        end else begin
            chk("no_done", done_cyc, -1);
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; log_ready = 1; tol = '0;
        set_frame(0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_all_zero("reset");

        // identical buffers
        set_frame(0);
        run_frame(0, -1, 0, -1, -1, -1, -1, 0);
        chk("t1_err_lit", err_count, 0);
        chk("t1_max_lit", max_abs, 0);

        // single +3 pixel at (2,5)
        set_frame(1);
        run_frame(0, -1, 0, -1, -1, -1, -1, 0);
        chk("t2_err_lit", err_count, 1);
        chk("t2_frow_lit", first_row, 2);
        chk("t2_fcol_lit", first_col, 5);
        chk("t2_max_lit", max_abs, 3);
        chk("t2_rec_lit", {last_row, last_beat, last_mask}, {32'd2, 32'd2, 32'd2});
        run_frame(3, -1, 0, -1, -1, -1, -1, 0);
        chk("t2b_err_lit", err_count, 0);
        chk("t2b_max_lit", max_abs, 3);

        // two-lane beat plus a single pixel
        set_frame(2);
        run_frame(0, -1, 0, -1, -1, -1, -1, 0);
        chk("t3_first_mask_lit", first_mask, 3);
        chk("t3_last_mask_lit", last_mask, 2);
        chk("t3_err_lit", err_count, 3);
        chk("t3_first_lit", {first_row, first_col}, {10'd1, 11'd0});
        chk("t3_max_lit", max_abs, 4);

        // every beat mismatches, consumer stalls for 5 cycles on the first record
        set_frame(3);
        run_frame(0, 3, 5, -1, -1, -1, -1, 0);
        chk("t4_err_sat_lit", err_count, 15);
        chk("t4_recs_lit", rec_cnt, 16);
        chk("t4_done_lit", done_cyc, 23);

        // abort mid-run keeps stats from beats 0..5, then a clean rerun
        run_frame(0, -1, 0, 7, -1, -1, -1, 0);
        chk("abort_err_kept", err_count, 12);
        run_frame(0, -1, 0, -1, -1, -1, -1, 0);
        chk("after_abort_err", err_count, 15);

        // reset mid-run, then a clean rerun
        run_frame(0, -1, 0, -1, 7, -1, -1, 0);
        run_frame(0, -1, 0, -1, -1, -1, -1, 0);

        // restart while busy and late tol change are ignored
        set_frame(1);
        run_frame(0, -1, 0, -1, -1, 5, 3, 3);
        chk("t6_err_lit", err_count, 1);

        // maximum tolerance never flags
        set_frame(4);
        run_frame(255, -1, 0, -1, -1, -1, -1, 0);
        chk("tmax_err_lit", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
